// File: rtl/rr_decoder_sequencer_pkg.sv
// Shared definitions for the round-robin decoder sequencer.
//   state_e   : sequencer states (idle, grant active, one-cycle gap)
//   NUM_REQ   : number of requesters / decoder outputs
//   IDX_W     : width of a grant index
//   LAST_RST  : reset value of the last-grant pointer (first priority to req[0])
package rr_decoder_sequencer_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned IDX_W   = 2;

   localparam logic [IDX_W-1:0] LAST_RST = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StGap
   } state_e;

endpackage

// File: rtl/rr_decoder_sequencer_rr_pick.sv
// Combinational round-robin picker.
//   req    [3:0] in  : request lines
//   last   [1:0] in  : index granted most recently
//   winner [1:0] out : first requester searching last+1, last+2, last+3, last
//   any          out : at least one request present
module rr_decoder_sequencer_rr_pick
   import rr_decoder_sequencer_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   winner,
   output logic               any
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      winner = last;
      found  = 1'b0;
      idx    = '0;
      any    = |req;
      for (int i = 1; i <= int'(NUM_REQ); i++) begin
         idx = last + IDX_W'(i);   // wraps mod 4, last itself checked last
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_decoder_sequencer.sv
// Four-way round-robin arbiter driving a 2-to-4 decoder's select inputs.
// Optional feature macro: GRANT_TIMEOUT_EN (force-release after MAX_HOLD cycles).
//   clk     in  : clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   req     in  : request lines, bit i requests decoder output i
//   done    in  : release pulse from the granted consumer (ignored outside a grant)
//   addr0   out : grant index bit 0, registered
//   addr1   out : grant index bit 1, registered
//   enable  out : decoder enable, registered, high only during a grant
//   busy    out : high in grant and gap states
//   timeout out : one-cycle pulse when a grant is force-released
module rr_decoder_sequencer
   import rr_decoder_sequencer_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic               addr0,
   output logic               addr1,
   output logic               enable,
   output logic               busy,
   output logic               timeout
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_param_chk
      $error("rr_decoder_sequencer: illegal MAX_HOLD/CNT_W");
   end

   state_e           state_q, state_d;
   logic [IDX_W-1:0] addr_q, addr_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic             enable_q, enable_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;
   logic [IDX_W-1:0] winner;
   logic             any;
   logic             hold_expired;

`ifdef GRANT_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
   assign hold_expired = 1'b0;
`endif

   rr_decoder_sequencer_rr_pick u_pick (
      .req    (req),
      .last   (last_q),
      .winner (winner),
      .any    (any)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      last_d    = last_q;
      enable_d  = enable_q;
      timeout_d = 1'b0;
`ifdef GRANT_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      unique case (state_q)
         StIdle, StGap: begin
            // Gap and idle share arbitration; gap is always exactly one cycle.
            if (any) begin
               state_d  = StGrant;
               addr_d   = winner;
               last_d   = winner;
               enable_d = 1'b1;
`ifdef GRANT_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end else begin
               state_d  = StIdle;
               enable_d = 1'b0;
            end
         end
         StGrant: begin
`ifdef GRANT_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (done) begin
               // done takes precedence over a coincident timeout
               state_d  = StGap;
               enable_d = 1'b0;
            end else if (hold_expired) begin
               state_d   = StGap;
               enable_d  = 1'b0;
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d  = StIdle;
            enable_d = 1'b0;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         last_q    <= LAST_RST;
         enable_q  <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         last_q    <= last_d;
         enable_q  <= enable_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef GRANT_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign addr0   = addr_q[0];
   assign addr1   = addr_q[1];
   assign enable  = enable_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule
